// File: rtl/branch_queue_mp.sv
// Circular branch queue: in-order push, multi-port out-of-order resolve, in-order commit pop, partial squash, flush.
// 1-cycle state update; define BQ_RESOLVE_BYPASS_EN to let a same-cycle resolve complete the head combinationally.
module branch_queue_mp #(
  parameter int NR_ENTRIES = 16,
  parameter int NR_RESOLVE = 2,
  parameter int XLEN       = 64,
  parameter int ID_W       = 8,
  localparam int B         = $clog2(NR_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [XLEN-1:0]            push_pc_i,
  input  logic [XLEN-1:0]            push_pcnext_i,
  input  logic                       push_taken_i,
  input  logic [ID_W-1:0]            push_id_i,
  output logic [B-1:0]               push_bqid_o,
  input  logic [NR_RESOLVE-1:0]      res_valid_i,
  input  logic [NR_RESOLVE*B-1:0]    res_bqid_i,
  input  logic [NR_RESOLVE*XLEN-1:0] res_pc_i,
  input  logic [NR_RESOLVE-1:0]      res_taken_i,
  input  logic                       pop_i,
  output logic                       head_valid_o,
  output logic [XLEN-1:0]            head_pcnext_o,
  output logic                       head_taken_o,
  output logic                       head_missp_o,
  output logic [ID_W-1:0]            head_id_o,
  input  logic                       squash_valid_i,
  input  logic [B-1:0]               squash_bqid_i,
  input  logic                       flush_i,
  output logic [B:0]                 count_o
);

  logic [B-1:0]      head_q, head_d, tail_q, tail_d;
  logic [B:0]        count_q, count_d;
  logic [ID_W-1:0]   id_q     [NR_ENTRIES];
  logic [XLEN-1:0]   pc_q     [NR_ENTRIES];
  logic [XLEN-1:0]   pcnext_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] taken_q, missp_q, resolved_q;

  logic              push_fire, pop_fire;
  logic [B-1:0]      sq_off;
  logic [B-1:0]      rbq  [NR_RESOLVE];
  logic [B-1:0]      roff [NR_RESOLVE];
  logic [XLEN-1:0]   rpc  [NR_RESOLVE];
  logic [NR_RESOLVE-1:0] res_ok, res_mp;

  logic              byp_hit, byp_taken, byp_mp;
  logic [XLEN-1:0]   byp_pc;

  // Per-port decode: a resolve counts only on a live entry that survives any same-cycle squash.
  always_comb begin
    sq_off = squash_bqid_i - head_q;
    res_ok = '0;
    res_mp = '0;
    for (int p = 0; p < NR_RESOLVE; p++) begin
      rbq[p]    = res_bqid_i[p*B +: B];
      rpc[p]    = res_pc_i[p*XLEN +: XLEN];
      roff[p]   = rbq[p] - head_q;
      res_ok[p] = res_valid_i[p] && !flush_i && ({1'b0, roff[p]} < count_q)
                  && (!squash_valid_i || (roff[p] <= sq_off));
      res_mp[p] = res_taken_i[p] ? (pcnext_q[rbq[p]] != rpc[p]) : taken_q[rbq[p]];
    end
  end

  always_comb begin
    byp_hit   = 1'b0;
    byp_pc    = '0;
    byp_taken = 1'b0;
    byp_mp    = 1'b0;
`ifdef BQ_RESOLVE_BYPASS_EN
    // Descending scan so the lowest-numbered port wins.
    for (int p = NR_RESOLVE-1; p >= 0; p--) begin
      if (res_valid_i[p] && (rbq[p] == head_q) && !resolved_q[head_q]) begin
        byp_hit   = 1'b1;
        byp_pc    = rpc[p];
        byp_taken = res_taken_i[p];
        byp_mp    = res_mp[p];
      end
    end
`endif
  end

  always_comb begin
    push_ready_o  = count_q < (B+1)'(NR_ENTRIES);
    push_bqid_o   = tail_q;
    count_o       = count_q;
    head_valid_o  = (count_q != '0) && (resolved_q[head_q] || byp_hit);
    head_pcnext_o = byp_hit ? byp_pc    : pcnext_q[head_q];
    head_taken_o  = byp_hit ? byp_taken : taken_q[head_q];
    head_missp_o  = byp_hit ? byp_mp    : missp_q[head_q];
    head_id_o     = id_q[head_q];
    push_fire     = push_valid_i && push_ready_o && !squash_valid_i && !flush_i;
    pop_fire      = pop_i && head_valid_o && !flush_i;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_fire) head_d = head_q + 1'b1;
      if (squash_valid_i) begin
        tail_d  = squash_bqid_i + 1'b1;
        count_d = {1'b0, sq_off} + (B+1)'(1) - {{B{1'b0}}, pop_fire};
      end else begin
        if (push_fire) tail_d = tail_q + 1'b1;
        count_d = count_q + {{B{1'b0}}, push_fire} - {{B{1'b0}}, pop_fire};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      resolved_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_fire) resolved_q[tail_q] <= 1'b0;
      for (int p = NR_RESOLVE-1; p >= 0; p--)
        if (res_ok[p]) resolved_q[rbq[p]] <= 1'b1;
    end
  end

  // Payload is not reset; liveness comes from head/count and resolved flags.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      id_q[tail_q]     <= push_id_i;
      pc_q[tail_q]     <= push_pc_i;
      pcnext_q[tail_q] <= push_pcnext_i;
      taken_q[tail_q]  <= push_taken_i;
    end
    for (int p = NR_RESOLVE-1; p >= 0; p--) begin
      if (res_ok[p]) begin
        pcnext_q[rbq[p]] <= rpc[p];
        taken_q[rbq[p]]  <= res_taken_i[p];
        missp_q[rbq[p]]  <= res_mp[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_valid_i && !push_ready_o) $warning("branch_queue_mp: push while full ignored");
      if (pop_i && !head_valid_o) $warning("branch_queue_mp: pop without valid head ignored");
      if (squash_valid_i && !flush_i && ({1'b0, sq_off} >= count_q))
        $warning("branch_queue_mp: squash index not live");
      for (int p = 0; p < NR_RESOLVE; p++)
        for (int q = p + 1; q < NR_RESOLVE; q++)
          if (res_valid_i[p] && res_valid_i[q] && (rbq[p] == rbq[q]))
            $warning("branch_queue_mp: ports %0d and %0d resolve same index", p, q);
    end
  end

endmodule

// File: tb/tb_branch_queue_mp.sv
// Scoreboard bench for branch_queue_mp: pushes record expected head payloads, pops compare them.
module tb_branch_queue_mp;
  localparam int N  = 16;
  localparam int NR = 2;
  localparam int XL = 64;
  localparam int IW = 8;
  localparam int B  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           push_valid_i, push_ready_o, push_taken_i;
  logic [XL-1:0]  push_pc_i, push_pcnext_i;
  logic [IW-1:0]  push_id_i;
  logic [B-1:0]   push_bqid_o;
  logic [NR-1:0]  res_valid_i, res_taken_i;
  logic [NR*B-1:0]  res_bqid_i;
  logic [NR*XL-1:0] res_pc_i;
  logic           pop_i, head_valid_o, head_taken_o, head_missp_o;
  logic [XL-1:0]  head_pcnext_o;
  logic [IW-1:0]  head_id_o;
  logic           squash_valid_i, flush_i;
  logic [B-1:0]   squash_bqid_i;
  logic [B:0]     count_o;

  branch_queue_mp dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_pcnext_i(push_pcnext_i), .push_taken_i(push_taken_i), .push_id_i(push_id_i),
    .push_bqid_o(push_bqid_o),
    .res_valid_i(res_valid_i), .res_bqid_i(res_bqid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .pop_i(pop_i), .head_valid_o(head_valid_o), .head_pcnext_o(head_pcnext_o),
    .head_taken_o(head_taken_o), .head_missp_o(head_missp_o), .head_id_o(head_id_o),
    .squash_valid_i(squash_valid_i), .squash_bqid_i(squash_bqid_i),
    .flush_i(flush_i), .count_o(count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [XL-1:0] m_pcnext [N];
  logic          m_taken  [N];
  logic          m_missp  [N];
  logic          m_res    [N];
  logic [IW-1:0] m_id     [N];
  int m_head, m_tail, m_cnt;
  int sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    push_valid_i = 0; push_pc_i = '0; push_pcnext_i = '0; push_taken_i = 0; push_id_i = '0;
    res_valid_i = '0; res_bqid_i = '0; res_pc_i = '0; res_taken_i = '0;
    pop_i = 0; squash_valid_i = 0; squash_bqid_i = '0; flush_i = 0;
  endtask

  function automatic int offs(input int idx);
    return ((idx - m_head) % N + N) % N;
  endfunction

  task automatic model_reset();
    m_head = 0; m_tail = 0; m_cnt = 0;
    sb.delete();
    for (int i = 0; i < N; i++) m_res[i] = 0;
  endtask

  task automatic model_res(input int idx, input logic [XL-1:0] pc, input logic tk);
    if (offs(idx) < m_cnt) begin
      m_missp[idx]  = tk ? (m_pcnext[idx] != pc) : m_taken[idx];
      m_pcnext[idx] = pc;
      m_taken[idx]  = tk;
      m_res[idx]    = 1;
    end
  endtask

  task automatic set_res(input int port, input int idx, input logic [XL-1:0] pc, input logic tk);
    res_valid_i[port]          = 1'b1;
    res_bqid_i[port*B +: B]    = idx[B-1:0];
    res_pc_i[port*XL +: XL]    = pc;
    res_taken_i[port]          = tk;
  endtask

  task automatic do_push(input logic [XL-1:0] pcn, input logic tk, input logic [IW-1:0] id);
    check("push_bqid", push_bqid_o, m_tail);
    check("push_ready", push_ready_o, m_cnt < N);
    push_valid_i = 1; push_pcnext_i = pcn; push_pc_i = pcn - 4; push_taken_i = tk; push_id_i = id;
    tick();
    push_valid_i = 0;
    settle();
    if (m_cnt < N) begin
      m_pcnext[m_tail] = pcn; m_taken[m_tail] = tk; m_id[m_tail] = id; m_res[m_tail] = 0;
      sb.push_back(m_tail);
      m_tail = (m_tail + 1) % N;
      m_cnt++;
    end
    check("count_after_push", count_o, m_cnt);
  endtask

  task automatic do_res(input int port, input int idx, input logic [XL-1:0] pc, input logic tk);
    set_res(port, idx, pc, tk);
    tick();
    res_valid_i = '0;
    settle();
    model_res(idx, pc, tk);
  endtask

  task automatic compare_head(input int idx);
    check("head_valid", head_valid_o, m_res[idx]);
    check("head_id", head_id_o, m_id[idx]);
    check("head_pcnext", head_pcnext_o, m_pcnext[idx]);
    check("head_taken", head_taken_o, m_taken[idx]);
    check("head_missp", head_missp_o, m_missp[idx]);
  endtask

  task automatic do_pop();
    int idx;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    idx = sb.pop_front();
    compare_head(idx);
    pop_i = 1;
    tick();
    pop_i = 0;
    settle();
    m_head = (m_head + 1) % N;
    m_cnt--;
    check("count_after_pop", count_o, m_cnt);
  endtask

  task automatic do_flush();
    flush_i = 1; push_valid_i = 1; push_pcnext_i = 64'hdead;
    tick();
    flush_i = 0; push_valid_i = 0;
    settle();
    model_reset();
    check("flush_count", count_o, 0);
    check("flush_bqid", push_bqid_o, 0);
    check("flush_hv", head_valid_o, 0);
  endtask

  initial begin
    int idx, sq;
    clear_inputs();
    model_reset();
    rst = 1;
    tick();
    tick();
    check("rst_ready", push_ready_o, 1);
    check("rst_hv", head_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_bqid", push_bqid_o, 0);
    rst = 0;
    settle();

    // Misprediction flag for taken / not-taken outcomes.
    do_push(64'h1000, 1, 8'h01);
    check("unresolved_hv", head_valid_o, 0);
    do_res(0, 0, 64'h1004, 1);
    do_pop();
    do_push(64'h1000, 1, 8'h02);
    do_res(1, 1, 64'h1000, 1);
    do_pop();
    do_push(64'h2000, 0, 8'h03);
    do_res(0, 2, 64'h2000, 0);
    do_pop();
    do_push(64'h2000, 1, 8'h04);
    do_res(0, 3, 64'h1ffc, 0);
    do_pop();
    do_flush();

    // Out-of-order dual-port resolve, then a same-index collision.
    for (int i = 0; i < 4; i++) do_push(64'h3000 + 64'(i * 16), i[0], IW'(8'h10 + i));
    set_res(0, 2, 64'h3020, 0);
    set_res(1, 0, 64'h3004, 1);
    tick();
    res_valid_i = '0;
    settle();
    model_res(2, 64'h3020, 0);
    model_res(0, 64'h3004, 1);
    check("dual_hv", head_valid_o, 1);
    check("dual_count", count_o, 4);
    do_pop();
    check("after_pop_hv", head_valid_o, 0);
    set_res(0, 1, 64'h3010, 1);
    set_res(1, 1, 64'h3999, 1);
    tick();
    res_valid_i = '0;
    settle();
    model_res(1, 64'h3010, 1);
    do_pop();
    do_pop();
    // Push and pop together keep the count.
    do_res(1, 3, 64'h3030, 1);
    idx = sb.pop_front();
    compare_head(idx);
    push_valid_i = 1; push_pcnext_i = 64'h3040; push_taken_i = 0; push_id_i = 8'h14; pop_i = 1;
    tick();
    push_valid_i = 0; pop_i = 0;
    settle();
    m_pcnext[m_tail] = 64'h3040; m_taken[m_tail] = 0; m_id[m_tail] = 8'h14; m_res[m_tail] = 0;
    sb.push_back(m_tail);
    m_tail = (m_tail + 1) % N;
    m_head = (m_head + 1) % N;
    check("pushpop_count", count_o, m_cnt);
    check("pushpop_bqid", push_bqid_o, 5);
    do_flush();

    // Fill to capacity; an extra push is ignored.
    for (int i = 0; i < N; i++) do_push(64'h4000 + 64'(i * 16), i[0], IW'(8'h40 + i));
    check("full_ready", push_ready_o, 0);
    check("full_count", count_o, 16);
    do_push(64'h5000, 1, 8'hff);
    check("full_tail", push_bqid_o, 0);
    check("full_count2", count_o, 16);

    // Drain 14 entries, refill 4 across the wrap, then squash together with a pop.
    for (int i = 0; i < 14; i++) begin
      do_res(i % 2, i, m_pcnext[i] + ((i % 3 == 0) ? 64'd4 : 64'd0), m_taken[i] ^ (i % 5 == 0));
      do_pop();
    end
    for (int i = 0; i < 4; i++) do_push(64'h6000 + 64'(i * 16), 1, IW'(8'h60 + i));
    check("wrap_count", count_o, 6);
    do_res(0, 14, 64'h40e0, 0);
    idx = sb.pop_front();
    compare_head(idx);
    pop_i = 1; squash_valid_i = 1; squash_bqid_i = 4'd0;
    set_res(0, 15, 64'h7000, 0);
    set_res(1, 2, 64'h7100, 1);
    push_valid_i = 1; push_pcnext_i = 64'h7200;
    tick();
    clear_inputs();
    settle();
    sq = offs(0);
    while (sb.size() > 0 && offs(sb[$]) > sq) void'(sb.pop_back());
    model_res(15, 64'h7000, 0);
    m_head = 15; m_tail = 1; m_cnt = 2;
    check("squash_count", count_o, 2);
    check("squash_bqid", push_bqid_o, 1);
    check("squash_res_kept_hv", head_valid_o, 1);
    do_pop();
    check("squash_head0_hv", head_valid_o, 0);

    // Reset in the middle of activity with a resolve pending.
    for (int i = 0; i < 4; i++) do_push(64'h8000 + 64'(i * 16), 0, IW'(8'h80 + i));
    check("pre_rst_count", count_o, 5);
    set_res(0, 0, 64'h9000, 1);
    rst = 1;
    tick();
    rst = 0;
    clear_inputs();
    settle();
    model_reset();
    check("mid_rst_count", count_o, 0);
    check("mid_rst_hv", head_valid_o, 0);
    check("mid_rst_ready", push_ready_o, 1);
    do_push(64'ha000, 1, 8'ha0);
    check("post_rst_hv", head_valid_o, 0);

    // Same-cycle completion of the head.
    set_res(1, 0, 64'ha008, 1);
    settle();
`ifdef BQ_RESOLVE_BYPASS_EN
    check("byp_hv_same", head_valid_o, 1);
    check("byp_pcnext", head_pcnext_o, 64'ha008);
    check("byp_missp", head_missp_o, 1);
`else
    check("nobyp_hv_same", head_valid_o, 0);
`endif
    tick();
    res_valid_i = '0;
    settle();
    model_res(0, 64'ha008, 1);
    check("byp_hv_next", head_valid_o, 1);
    do_pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
